// File: rtl/oneshot_multi_if.sv
// Trigger/config inputs and pulse/status outputs of the multi-channel one-shot.
interface oneshot_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int OVR_W = 8
);
  logic [NCH-1:0]       pulse;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       retrig;
  logic [CNT_W-1:0]     pw;
  logic                 ovr_clr;
  logic [NCH-1:0]       pout;
  logic [NCH-1:0]       busy;
  logic [NCH*OVR_W-1:0] ovr_cnt;

  modport master (output pulse, en, retrig, pw, ovr_clr, input pout, busy, ovr_cnt);
  modport slave  (input pulse, en, retrig, pw, ovr_clr, output pout, busy, ovr_cnt);
endinterface

// File: rtl/oneshot_multi.sv
// Multi-channel pulse stretcher with per-channel retrigger mode and dead time.
// Define ONESHOT_OVERRUN_EN to build the saturating per-channel overrun counters.
module oneshot_multi #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2,
  parameter int OVR_W   = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  oneshot_multi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  localparam logic [CNT_W-1:0] HO_M1 = CNT_W'(HOLDOFF - 1);

  state_t           state    [NCH];
  state_t           state_nx [NCH];
  logic [CNT_W-1:0] cnt      [NCH];
  logic [CNT_W-1:0] cnt_nx   [NCH];
  logic [NCH-1:0]   pulse_d;
  logic [NCH-1:0]   edge_det;
  logic [NCH-1:0]   pout_q, pout_nx;
  logic [NCH-1:0]   busy_q, busy_nx;
  logic [NCH-1:0]   ovr_ev;
  logic [CNT_W-1:0] pw_m1;
  logic             pw_ok;

  // Edge register tracks the input even while disabled, so re-enabling on a held level does not fire.
  assign edge_det = bus.pulse & ~pulse_d;
  assign pw_ok    = (bus.pw != '0);
  assign pw_m1    = bus.pw - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_d <= '0;
      pout_q  <= '0;
      busy_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      pulse_d <= bus.pulse;
      pout_q  <= pout_nx;
      busy_q  <= busy_nx;
      for (int unsigned i = 0; i < NCH; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  always_comb begin
    pout_nx = '0;
    busy_nx = '0;
    ovr_ev  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      if (!bus.en[i]) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
      end else begin
        unique case (state[i])
          IDLE: begin
            if (edge_det[i] && pw_ok) begin
              state_nx[i] = ACTIVE;
              cnt_nx[i]   = pw_m1;
            end
          end
          ACTIVE: begin
            // Reload has priority over expiry so a retrigger on the last cycle leaves no gap.
            if (edge_det[i] && bus.retrig[i] && pw_ok) begin
              cnt_nx[i] = pw_m1;
            end else begin
              ovr_ev[i] = edge_det[i] & ~bus.retrig[i];
              if (cnt[i] != '0) begin
                cnt_nx[i] = cnt[i] - CNT_W'(1);
              end else if (HOLDOFF != 0) begin
                state_nx[i] = HOLD;
                cnt_nx[i]   = HO_M1;
              end else begin
                state_nx[i] = IDLE;
              end
            end
          end
          HOLD: begin
            ovr_ev[i] = edge_det[i];
            if (cnt[i] != '0) cnt_nx[i] = cnt[i] - CNT_W'(1);
            else              state_nx[i] = IDLE;
          end
          default: begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end
        endcase
      end
      pout_nx[i] = (state_nx[i] == ACTIVE);
      busy_nx[i] = (state_nx[i] != IDLE);
    end
  end

  assign bus.pout = pout_q;
  assign bus.busy = busy_q;

`ifdef ONESHOT_OVERRUN_EN
  logic [OVR_W-1:0] ovr [NCH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) ovr[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (bus.ovr_clr)                   ovr[i] <= '0;
        else if (ovr_ev[i] && ovr[i] != '1) ovr[i] <= ovr[i] + OVR_W'(1);
      end
    end
  end

  always_comb begin
    bus.ovr_cnt = '0;
    for (int unsigned i = 0; i < NCH; i++) bus.ovr_cnt[i*OVR_W +: OVR_W] = ovr[i];
  end
`else
  logic unused_ovr;
  assign unused_ovr  = bus.ovr_clr ^ (^ovr_ev);
  assign bus.ovr_cnt = '0;
`endif

endmodule
